// File: rtl/game_pkg.sv
// Shared encodings for the race display pipeline: screen modes, winner codes, timing defaults.
// Constants only; no logic, no latency.
package game_pkg;

  typedef enum logic [1:0] {
    MODE_MENU      = 2'd0,
    MODE_COUNTDOWN = 2'd1,
    MODE_RACE      = 2'd2,
    MODE_RESULT    = 2'd3
  } mode_e;

  // Bit 0 is player 1 and bit 1 is player 2, so both set reads as a tie.
  typedef enum logic [1:0] {
    WIN_NONE = 2'd0,
    WIN_P1   = 2'd1,
    WIN_P2   = 2'd2,
    WIN_TIE  = 2'd3
  } winner_e;

  localparam int          FRAMES_PER_STEP_DEFAULT = 60;
  localparam logic [1:0]  LIGHT_FIRST             = 2'd3;

endpackage

// File: rtl/frame_tick_gen.sv
// Frame boundary detector: tick is combinational on the vblnk rising edge, frame_tick is tick one cycle later.
// The delay register resets high so vblnk already high at reset release never produces a tick; no backpressure.
module frame_tick_gen (
  input  logic clk,
  input  logic rst,
  input  logic vblnk_in,
  output logic tick,
  output logic frame_tick
);

  logic vblnk_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vblnk_d    <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      vblnk_d    <= vblnk_in;
      frame_tick <= tick;
    end
  end

  assign tick = vblnk_in & ~vblnk_d;

endmodule

// File: rtl/game_flow_ctrl.sv
// Game phase sequencer (menu, countdown, race, result); every state/output change lands on the frame tick edge.
// Outputs are registered and hold for the whole following frame; inputs are sampled, never stalled.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int FRAMES_PER_STEP = FRAMES_PER_STEP_DEFAULT,
  parameter int TIME_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vblnk_in,
  input  logic              start_in,
  input  logic              p1_finish_in,
  input  logic              p2_finish_in,
  output logic [1:0]        screen_mode,
  output logic [1:0]        countdown,
  output logic [TIME_W-1:0] race_time,
  output logic [1:0]        winner,
  output logic              frame_tick
);

  localparam int                STEP_W    = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(FRAMES_PER_STEP - 1);

  logic tick;

  frame_tick_gen u_tick (
    .clk        (clk),
    .rst        (rst),
    .vblnk_in   (vblnk_in),
    .tick       (tick),
    .frame_tick (frame_tick)
  );

  mode_e              state,      state_nxt;
  logic [1:0]         light,      light_nxt;
  logic [STEP_W-1:0]  step_cnt,   step_nxt;
  logic [TIME_W-1:0]  time_q,     time_nxt;
  winner_e            win_q,      win_nxt;
  logic               start_pend, pend_nxt;
  logic               p1_fin,     p1_nxt;
  logic               p2_fin,     p2_nxt;

  logic pend_now, p1_now, p2_now, flags_clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= MODE_MENU;
      light      <= '0;
      step_cnt   <= '0;
      time_q     <= '0;
      win_q      <= WIN_NONE;
      start_pend <= 1'b0;
      p1_fin     <= 1'b0;
      p2_fin     <= 1'b0;
    end else begin
      state      <= state_nxt;
      light      <= light_nxt;
      step_cnt   <= step_nxt;
      time_q     <= time_nxt;
      win_q      <= win_nxt;
      start_pend <= pend_nxt;
      p1_fin     <= p1_nxt;
      p2_fin     <= p2_nxt;
    end
  end

  // Requests arriving in the tick cycle itself count toward that tick's decision.
  always_comb begin
    pend_now  = start_pend | start_in;
    p1_now    = p1_fin | p1_finish_in;
    p2_now    = p2_fin | p2_finish_in;
    state_nxt = state;
    light_nxt = light;
    step_nxt  = step_cnt;
    time_nxt  = time_q;
    win_nxt   = win_q;

    if (tick) begin
      case (state)
        MODE_MENU: begin
          if (pend_now) begin
            state_nxt = MODE_COUNTDOWN;
            light_nxt = LIGHT_FIRST;
            step_nxt  = '0;
            time_nxt  = '0;
            win_nxt   = WIN_NONE;
          end
        end
        MODE_COUNTDOWN: begin
          if (step_cnt == STEP_LAST) begin
            step_nxt = '0;
            if (light == 2'd1) begin
              state_nxt = MODE_RACE;
              light_nxt = '0;
            end else begin
              light_nxt = light - 2'd1;
            end
          end else begin
            step_nxt = step_cnt + STEP_W'(1);
          end
        end
        MODE_RACE: begin
          if (time_q != '1) time_nxt = time_q + TIME_W'(1);
          if (p1_now | p2_now) begin
            state_nxt = MODE_RESULT;
            win_nxt   = winner_e'({p2_now, p1_now});
          end
        end
        MODE_RESULT: begin
          if (pend_now) begin
            state_nxt = MODE_MENU;
            light_nxt = '0;
            time_nxt  = '0;
            win_nxt   = WIN_NONE;
          end
        end
        default: state_nxt = MODE_MENU;
      endcase
    end

    // Crossings seen before the race proper starts are thrown away.
    flags_clr = ((state_nxt == MODE_COUNTDOWN) && (state != MODE_COUNTDOWN)) ||
                ((state_nxt == MODE_RACE)      && (state != MODE_RACE));
    p1_nxt    = flags_clr ? 1'b0 : p1_now;
    p2_nxt    = flags_clr ? 1'b0 : p2_now;
    pend_nxt  = tick ? 1'b0 : pend_now;
  end

  always_comb begin
    screen_mode = state;
    countdown   = light;
    race_time   = time_q;
    winner      = win_q;
  end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: random frames and requests, frame-level reference model feeding a scoreboard.
// The monitor compares all outputs on every frame_tick pulse.
module tb_game_flow_ctrl;

  localparam int FPS  = 2;
  localparam int TW   = 4;
  localparam int TMAX = (1 << TW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          vblnk_in, start_in, p1_finish_in, p2_finish_in;
  logic [1:0]    screen_mode, countdown, winner;
  logic [TW-1:0] race_time;
  logic          frame_tick;

  game_flow_ctrl #(.FRAMES_PER_STEP(FPS), .TIME_W(TW)) dut (
    .clk          (clk),
    .rst          (rst),
    .vblnk_in     (vblnk_in),
    .start_in     (start_in),
    .p1_finish_in (p1_finish_in),
    .p2_finish_in (p2_finish_in),
    .screen_mode  (screen_mode),
    .countdown    (countdown),
    .race_time    (race_time),
    .winner       (winner),
    .frame_tick   (frame_tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    int mode;
    int light;
    int rtime;
    int win;
  } exp_t;

  exp_t q[$];

  // Reference model: phase plus "frames spent in countdown"; the light is derived from that count.
  int m_mode, m_n, m_time, m_win;
  bit m_vd, m_pend, m_p1, m_p2;

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0; m_n = 0; m_time = 0; m_win = 0;
      m_vd = 1'b1; m_pend = 1'b0; m_p1 = 1'b0; m_p2 = 1'b0;
      q.delete();
    end else begin
      bit   tk, pend, f1, f2, clr;
      int   prev;
      exp_t e;
      tk   = vblnk_in & ~m_vd;
      pend = m_pend | start_in;
      f1   = m_p1 | p1_finish_in;
      f2   = m_p2 | p2_finish_in;
      prev = m_mode;
      if (tk) begin
        case (m_mode)
          0: if (pend) begin m_mode = 1; m_n = 0; m_time = 0; m_win = 0; end
          1: begin
            m_n++;
            if (m_n == 3 * FPS) m_mode = 2;
          end
          2: begin
            if (m_time < TMAX) m_time++;
            if (f1 || f2) begin m_mode = 3; m_win = 2 * f2 + f1; end
          end
          default: if (pend) begin m_mode = 0; m_time = 0; m_win = 0; end
        endcase
        e.mode  = m_mode;
        e.light = (m_mode == 1) ? 3 - m_n / FPS : 0;
        e.rtime = m_time;
        e.win   = m_win;
        q.push_back(e);
      end
      clr    = (m_mode != prev) && (m_mode == 1 || m_mode == 2);
      m_p1   = clr ? 1'b0 : f1;
      m_p2   = clr ? 1'b0 : f2;
      m_pend = tk ? 1'b0 : pend;
      m_vd   = vblnk_in;
    end
  end

  always @(negedge clk) begin
    if (!rst && frame_tick) begin
      if (q.size() == 0) begin
        chk("unexpected_frame_tick", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("screen_mode", screen_mode, e.mode);
        chk("countdown",   countdown,   e.light);
        chk("race_time",   race_time,   e.rtime);
        chk("winner",      winner,      e.win);
      end
    end
  end

  // One frame: active part of random length, then vblnk high; requests go high at a random
  // cycle (possibly the tick cycle itself) as a pulse or held level.
  task automatic frame(input bit s, input bit a, input bit b);
    int lo, hi, at;
    bit lvl, on;
    lo  = $urandom_range(3, 8);
    hi  = $urandom_range(1, 5);
    at  = $urandom_range(0, lo);
    lvl = ($urandom_range(0, 3) == 0);
    for (int i = 0; i < lo + hi; i++) begin
      @(negedge clk);
      vblnk_in     = (i >= lo);
      on           = lvl ? (i >= at) : (i == at);
      start_in     = s & on;
      p1_finish_in = a & on;
      p2_finish_in = b & on;
    end
    @(negedge clk);
    start_in = 1'b0; p1_finish_in = 1'b0; p2_finish_in = 1'b0;
  endtask

  task automatic to_race();
    frame(1, 0, 0);
    for (int i = 0; i < 3 * FPS; i++) frame(i == 1, i == 2, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_mode"},   screen_mode, 0);
    chk({tag, "_light"},  countdown,   0);
    chk({tag, "_time"},   race_time,   0);
    chk({tag, "_winner"}, winner,      0);
    chk({tag, "_ftick"},  frame_tick,  0);
  endtask

  initial begin
    rst = 1'b1; vblnk_in = 1'b1; start_in = 1'b0; p1_finish_in = 1'b0; p2_finish_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk_reset_vals("post_reset");
    end

    frame(0, 0, 0);
    frame(0, 1, 0);
    to_race();
    for (int i = 1; i <= 5; i++) frame(0, 0, i == 5);
    chk("race5_mode",   screen_mode, 3);
    chk("race5_winner", winner,      2);
    chk("race5_time",   race_time,   5);
    frame(0, 0, 0);
    chk("result_frozen_time", race_time, 5);
    frame(1, 0, 0);
    chk("back_menu_mode", screen_mode, 0);

    to_race();
    frame(0, 0, 0);
    frame(0, 1, 1);
    chk("tie_mode",   screen_mode, 3);
    chk("tie_winner", winner,      3);
    frame(1, 0, 0);
    chk("tie_menu_mode",   screen_mode, 0);
    chk("tie_menu_time",   race_time,   0);
    chk("tie_menu_winner", winner,      0);

    to_race();
    for (int i = 0; i < TMAX + 3; i++) frame(0, 0, 0);
    frame(0, 1, 0);
    chk("sat_time",   race_time, TMAX);
    chk("sat_winner", winner,    1);
    frame(1, 0, 0);

    to_race();
    frame(0, 0, 0);
    frame(0, 0, 0);
    chk("pre_rst_mode", screen_mode, 2);
    #1 rst = 1'b1;
    #1 chk_reset_vals("async_rst");
    vblnk_in = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_release_ftick", frame_tick, 0);
    end

    for (int i = 0; i < 60; i++)
      frame($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);

    vblnk_in = 1'b0;
    repeat (4) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
